// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard receiver: pin sync, clock deglitch, frame deserialise, E0/F0 key-event assembly
`timescale 1ns/1ps
module ps2_kbd_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic       CLK_50M,
    input  logic       RST_N,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic [7:0] key_code_o,
    output logic       key_ext_o,
    output logic       key_rel_o,
    output logic       key_vld_o,
    output logic       err_o
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_filt_clk;
    logic [FW-1:0] r_filt_cnt;
    logic [TW-1:0] r_to_cnt;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic          r_ext, r_rel;
    state_t        r_state, w_state_nxt;

    logic [7:0]    r_byte, r_key_code;
    logic          r_byte_vld, r_key_ext, r_key_rel, r_key_vld, r_err;

    logic w_filt_flip, w_fall, w_timeout;
    logic w_frame_end, w_frame_ok, w_frame_bad, w_is_e0, w_is_f0;

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk_i;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_dat_i;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // The filtered clock follows only after FILTER_LEN consecutive differing samples
    assign w_filt_flip = (r_clk_s2 != r_filt_clk) && (r_filt_cnt == FW'(FILTER_LEN - 1));
    assign w_fall      = w_filt_flip && r_filt_clk;

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
        end else if (r_clk_s2 == r_filt_clk) begin
            r_filt_cnt <= '0;
        end else if (w_filt_flip) begin
            r_filt_clk <= r_clk_s2;
            r_filt_cnt <= '0;
        end else if (r_filt_cnt != FW'(FILTER_LEN)) begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_fall && !r_dat_s2) w_state_nxt = S_DATA;
            S_DATA:   if (w_fall && r_bit_cnt == 4'd7) w_state_nxt = S_PARITY;
            S_PARITY: if (w_fall) w_state_nxt = S_STOP;
            S_STOP:   if (w_fall) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (w_timeout) w_state_nxt = S_IDLE;
    end

    always_comb begin
        w_frame_end = (r_state == S_STOP) && w_fall;
        w_frame_ok  = w_frame_end && r_dat_s2 && (^{r_shift, r_par});
        w_frame_bad = (w_frame_end && !w_frame_ok) || w_timeout;
        w_is_e0     = (r_shift == 8'hE0);
        w_is_f0     = (r_shift == 8'hF0);
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            r_to_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_fall)        r_to_cnt <= '0;
            else if (r_to_cnt != TW'(TIMEOUT_CYC))  r_to_cnt <= r_to_cnt + 1'b1;

            if (r_state == S_IDLE && w_fall && !r_dat_s2) begin
                r_bit_cnt <= '0;
            end else if (r_state == S_DATA && w_fall) begin
                r_shift <= {r_dat_s2, r_shift[7:1]};
                if (r_bit_cnt != 4'hF) r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if (r_state == S_PARITY && w_fall) begin
                r_par <= r_dat_s2;
            end
        end
    end

    // Prefix flags survive a timeout but are dropped by a bad frame
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            r_byte     <= '0;
            r_byte_vld <= 1'b0;
            r_key_code <= '0;
            r_key_ext  <= 1'b0;
            r_key_rel  <= 1'b0;
            r_key_vld  <= 1'b0;
            r_err      <= 1'b0;
            r_ext      <= 1'b0;
            r_rel      <= 1'b0;
        end else begin
            r_byte_vld <= w_frame_ok;
            r_key_vld  <= w_frame_ok && !w_is_e0 && !w_is_f0;
            r_err      <= w_frame_bad;
            if (w_frame_ok) begin
                r_byte <= r_shift;
                if (w_is_e0) begin
                    r_ext <= 1'b1;
                end else if (w_is_f0) begin
                    r_rel <= 1'b1;
                end else begin
                    r_key_code <= r_shift;
                    r_key_ext  <= r_ext;
                    r_key_rel  <= r_rel;
                    r_ext      <= 1'b0;
                    r_rel      <= 1'b0;
                end
            end else if (w_frame_end) begin
                r_ext <= 1'b0;
                r_rel <= 1'b0;
            end
        end
    end

    assign byte_o     = r_byte;
    assign byte_vld_o = r_byte_vld;
    assign key_code_o = r_key_code;
    assign key_ext_o  = r_key_ext;
    assign key_rel_o  = r_key_rel;
    assign key_vld_o  = r_key_vld;
    assign err_o      = r_err;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - directed scoreboard bench for ps2_kbd_rx
`timescale 1ns/1ps
module tb_ps2_kbd_rx;
    localparam int FL   = 8;
    localparam int TO   = 200;
    localparam int HALF = 20;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } key_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk, ps2_dat;
    logic [7:0] byte_o, key_code_o;
    logic       byte_vld_o, key_ext_o, key_rel_o, key_vld_o, err_o;

    logic [7:0] exp_byte_q[$];
    key_t       exp_key_q[$];
    int         exp_err_q[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         last_fall_cyc = 0;
    bit         m_ext = 0, m_rel = 0;

    ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .CLK_50M   (clk),
        .RST_N     (rst_n),
        .ps2_clk_i (ps2_clk),
        .ps2_dat_i (ps2_dat),
        .byte_o    (byte_o),
        .byte_vld_o(byte_vld_o),
        .key_code_o(key_code_o),
        .key_ext_o (key_ext_o),
        .key_rel_o (key_rel_o),
        .key_vld_o (key_vld_o),
        .err_o     (err_o)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        key_t k;
        int   e;
        @(posedge clk);
        #1;
        cyc++;
        if (err_o || byte_vld_o) chk("err_byte_overlap", 32'(err_o & byte_vld_o), 32'd0);
        if (byte_vld_o) begin
            if (exp_byte_q.size() == 0) chk("byte_vld_unexpected", 32'(byte_vld_o), 32'd0);
            else                        chk("byte_o", 32'(byte_o), 32'(exp_byte_q.pop_front()));
        end
        if (key_vld_o) begin
            if (exp_key_q.size() == 0) begin
                chk("key_vld_unexpected", 32'(key_vld_o), 32'd0);
            end else begin
                k = exp_key_q.pop_front();
                chk("key_event", 32'({key_code_o, key_ext_o, key_rel_o}), 32'(k));
            end
        end
        if (err_o) begin
            if (exp_err_q.size() == 0) begin
                chk("err_unexpected", 32'(err_o), 32'd0);
            end else begin
                e = exp_err_q.pop_front();
                if (e >= 0) chk("timeout_latency", 32'(cyc), 32'(e));
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic flip, input logic stop);
        return {stop, ~(^d) ^ flip, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            idle(HALF / 2);
            ps2_dat = bits[i];
            if (glitch) begin
                idle(3);
                ps2_clk = 1'b0;
                idle(5);
                ps2_clk = 1'b1;
                idle(2);
            end else begin
                idle(HALF / 2);
            end
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            idle(HALF);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic good_frame(input logic [7:0] d, input bit glitch);
        exp_byte_q.push_back(d);
        if (d == 8'hE0)      m_ext = 1;
        else if (d == 8'hF0) m_rel = 1;
        else begin
            exp_key_q.push_back('{code: d, ext: m_ext, rel: m_rel});
            m_ext = 0;
            m_rel = 0;
        end
        send_bits(frame(d, 1'b0, 1'b1), 11, glitch);
        idle(40);
    endtask

    task automatic bad_frame(input logic [7:0] d, input logic flip, input logic stop);
        exp_err_q.push_back(-1);
        m_ext = 0;
        m_rel = 0;
        send_bits(frame(d, flip, stop), 11, 1'b0);
        idle(40);
    endtask

    task automatic drained(input string tag);
        chk({tag, "_bytes_pending"}, 32'(exp_byte_q.size()), 32'd0);
        chk({tag, "_keys_pending"},  32'(exp_key_q.size()),  32'd0);
        chk({tag, "_errs_pending"},  32'(exp_err_q.size()),  32'd0);
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_byte_o"},     32'(byte_o),     32'd0);
        chk({tag, "_byte_vld_o"}, 32'(byte_vld_o), 32'd0);
        chk({tag, "_key_code_o"}, 32'(key_code_o), 32'd0);
        chk({tag, "_key_flags"},  32'({key_ext_o, key_rel_o}), 32'd0);
        chk({tag, "_key_vld_o"},  32'(key_vld_o),  32'd0);
        chk({tag, "_err_o"},      32'(err_o),      32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        idle(3);
        outputs_zero("reset");
        rst_n = 1'b1;
        idle(5);

        good_frame(8'h1C, 0);
        drained("make_1c");
        chk("hold_key_code", 32'(key_code_o), 32'h1C);

        good_frame(8'hF0, 0);
        good_frame(8'h1C, 0);
        drained("break_1c");
        good_frame(8'hE0, 0);
        good_frame(8'hF0, 0);
        good_frame(8'h75, 0);
        drained("ext_break_75");

        bad_frame(8'h1C, 1'b1, 1'b1);
        chk("parity_err_key_hold", 32'({key_code_o, key_ext_o, key_rel_o}), 32'({8'h75, 1'b1, 1'b1}));
        chk("parity_err_byte_hold", 32'(byte_o), 32'h75);
        bad_frame(8'h1C, 1'b0, 1'b0);
        drained("frame_errs");

        good_frame(8'hF0, 0);
        send_bits(frame(8'h29, 1'b0, 1'b1), 5, 1'b0);
        exp_err_q.push_back(last_fall_cyc + 2 + FL + TO);
        idle(TO + 40);
        drained("timeout");
        good_frame(8'h29, 0);
        drained("after_timeout");

        good_frame(8'h5A, 1);
        drained("glitch_5a");

        send_bits(frame(8'h76, 1'b0, 1'b1), 6, 1'b0);
        rst_n = 1'b0;
        #1;
        outputs_zero("mid_frame_reset");
        idle(50);
        rst_n = 1'b1;
        m_ext = 0;
        m_rel = 0;
        idle(10);
        good_frame(8'h76, 0);
        drained("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
